// File: rtl/var_delay_ctrl_if.sv
// Stream, configuration and status signals of var_delay_ctrl.
// VAR_DELAY_CNT_EN adds the o_acc_cnt accepted-sample counter.
interface var_delay_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DLY_WIDTH  = 7
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_x0;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_y0;
  logic                  i_cfg_req;
  logic [DLY_WIDTH-1:0]  i_cfg_delay;
  logic                  o_cfg_ack;
  logic                  o_cfg_err;
  logic [DLY_WIDTH-1:0]  o_delay;
`ifdef VAR_DELAY_CNT_EN
  logic [31:0]           o_acc_cnt;

  modport master (
    output i_valid, i_x0, i_cfg_req, i_cfg_delay,
    input  o_ready, o_valid, o_y0, o_cfg_ack, o_cfg_err, o_delay, o_acc_cnt
  );

  modport slave (
    input  i_valid, i_x0, i_cfg_req, i_cfg_delay,
    output o_ready, o_valid, o_y0, o_cfg_ack, o_cfg_err, o_delay, o_acc_cnt
  );
`else
  modport master (
    output i_valid, i_x0, i_cfg_req, i_cfg_delay,
    input  o_ready, o_valid, o_y0, o_cfg_ack, o_cfg_err, o_delay
  );

  modport slave (
    input  i_valid, i_x0, i_cfg_req, i_cfg_delay,
    output o_ready, o_valid, o_y0, o_cfg_ack, o_cfg_err, o_delay
  );
`endif
endinterface

// File: rtl/var_delay_ctrl.sv
// Runtime-programmable sample delay built on a MAX_DEPTH-entry circular
// buffer. Every (re)configuration and every reset zero-fills the buffer so
// the output starts with D zeros, like a fixed shift-register delay.
// Optional feature macro: VAR_DELAY_CNT_EN (accepted-sample counter).
module var_delay_ctrl #(
  parameter int MAX_DEPTH     = 64,
  parameter int DATA_WIDTH    = 16,
  parameter int DLY_WIDTH     = $clog2(MAX_DEPTH + 1),
  parameter int DEFAULT_DELAY = 2
) (
  input  logic clk,
  input  logic rst,
  var_delay_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(MAX_DEPTH);
  localparam int SUM_W = DLY_WIDTH + 1;
  localparam logic [PTR_W-1:0]     LAST_IDX = PTR_W'(MAX_DEPTH - 1);
  localparam logic [DLY_WIDTH-1:0] MAX_D    = DLY_WIDTH'(MAX_DEPTH);
  localparam logic [DLY_WIDTH-1:0] DEF_D    = DLY_WIDTH'(DEFAULT_DELAY);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DLY_WIDTH-1:0]  delay_q, delay_d;
  logic [DLY_WIDTH-1:0]  pend_q, pend_d;
  logic                  ack_due_q, ack_due_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
`ifdef VAR_DELAY_CNT_EN
  logic [31:0]           acc_cnt_q, acc_cnt_d;
`endif

  logic [DATA_WIDTH-1:0] mem [MAX_DEPTH];
  logic                  mem_we;
  logic [PTR_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [SUM_W-1:0]      rd_wide;
  logic [PTR_W-1:0]      rd_idx;

  // Read index trails the write pointer by D entries, modulo MAX_DEPTH
  always_comb begin
    rd_wide = SUM_W'(wr_ptr_q) + SUM_W'(MAX_D) - SUM_W'(delay_q);
    if (rd_wide >= SUM_W'(MAX_D)) begin
      rd_wide = rd_wide - SUM_W'(MAX_D);
    end
    rd_idx = PTR_W'(rd_wide);
  end

  // Controller next-state: zero-fill sequence, sample path and config handshake
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    delay_d   = delay_q;
    pend_d    = pend_q;
    ack_due_d = ack_due_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    y_d       = y_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = bus.i_x0;
`ifdef VAR_DELAY_CNT_EN
    acc_cnt_d = acc_cnt_q;
`endif
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clr_cnt_q == LAST_IDX) begin
          clr_cnt_d = '0;
          wr_ptr_d  = '0;
          delay_d   = pend_q;
          state_d   = RUN;
          ready_d   = 1'b1;
          ack_d     = ack_due_q;
          ack_due_d = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.i_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
          valid_d  = 1'b1;
          y_d      = (delay_q == '0) ? bus.i_x0 : mem[rd_idx];
`ifdef VAR_DELAY_CNT_EN
          if (acc_cnt_q != 32'hFFFF_FFFF) begin
            acc_cnt_d = acc_cnt_q + 32'd1;
          end
`endif
        end
        if (bus.i_cfg_req && !ack_q) begin
          if (bus.i_cfg_delay > MAX_D) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else begin
            pend_d    = bus.i_cfg_delay;
            state_d   = CLEAR;
            ready_d   = 1'b0;
            ack_due_d = 1'b1;
            clr_cnt_d = '0;
`ifdef VAR_DELAY_CNT_EN
            acc_cnt_d = '0;
`endif
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ready_d = 1'b0;
      end
    endcase
  end

  // Register all controller state and the registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      delay_q   <= DEF_D;
      pend_q    <= DEF_D;
      ack_due_q <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef VAR_DELAY_CNT_EN
      acc_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      delay_q   <= delay_d;
      pend_q    <= pend_d;
      ack_due_q <= ack_due_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      y_q       <= y_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
`ifdef VAR_DELAY_CNT_EN
      acc_cnt_q <= acc_cnt_d;
`endif
    end
  end

  // Buffer storage; the read above sees the old contents (read-before-write)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_y0      = y_q;
  assign bus.o_cfg_ack = ack_q;
  assign bus.o_cfg_err = err_q;
  assign bus.o_delay   = delay_q;
`ifdef VAR_DELAY_CNT_EN
  assign bus.o_acc_cnt = acc_cnt_q;
`endif

endmodule

// File: tb/tb_var_delay_ctrl.sv
// Bench for var_delay_ctrl with MAX_DEPTH=8, DEFAULT_DELAY=2.
// A shift-register reference model predicts each output into a queue;
// a negedge monitor pops and compares whenever o_valid is seen.
module tb_var_delay_ctrl;

  localparam int MAX_DEPTH = 8;
  localparam int DW        = 16;
  localparam int DLW       = $clog2(MAX_DEPTH + 1);

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   model_d;
  logic [DW-1:0] line_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_y;

  var_delay_ctrl_if #(.DATA_WIDTH(DW), .DLY_WIDTH(DLW)) bus ();

  var_delay_ctrl #(
    .MAX_DEPTH(MAX_DEPTH),
    .DATA_WIDTH(DW),
    .DLY_WIDTH(DLW),
    .DEFAULT_DELAY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference delay line: D zeros of history after every clear
  task automatic modelClear(input int d);
    model_d = d;
    line_q.delete();
    repeat (d) line_q.push_back('0);
  endtask

  task automatic modelAccept(input logic [DW-1:0] x);
    line_q.push_back(x);
    exp_q.push_back(line_q.pop_front());
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("y0", 32'(bus.o_y0), 32'(exp_q.pop_front()));
        last_y = bus.o_y0;
      end
    end
  end

  // Drive one sample, called at a negedge; returns at the following negedge
  task automatic applyStimulus(input logic [DW-1:0] x);
    int guard = 0;
    while (!bus.o_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.o_ready) begin
      checkOutput("ready_wait", 32'd0, 32'd1);
    end else begin
      bus.i_valid = 1'b1;
      bus.i_x0    = x;
      modelAccept(x);
      @(negedge clk);
      bus.i_valid = 1'b0;
      checkOutput("latency", 32'(bus.o_valid), 32'd1);
    end
  endtask

  // Accepted reconfiguration: ack after MAX_DEPTH+1 cycles, o_ready low meanwhile
  task automatic requestDelay(input int d);
    int n = 0;
    int low = 0;
    bus.i_cfg_req   = 1'b1;
    bus.i_cfg_delay = DLW'(d);
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (!bus.o_ready) low++;
      if (bus.o_cfg_ack) break;
    end
    bus.i_cfg_req = 1'b0;
    checkOutput("ack_latency", 32'(n), 32'(MAX_DEPTH + 1));
    checkOutput("ready_low", 32'(low), 32'(MAX_DEPTH));
    checkOutput("ack_err", 32'(bus.o_cfg_err), 32'd0);
    checkOutput("ack_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("new_delay", 32'(bus.o_delay), 32'(d));
    modelClear(d);
    @(negedge clk);
    checkOutput("ack_pulse", 32'(bus.o_cfg_ack), 32'd0);
  endtask

  task automatic waitReady(input string tag);
    int cyc = 0;
    int acks = 0;
    while (!bus.o_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.o_cfg_ack) acks++;
    end
    checkOutput(tag, 32'(cyc), 32'(MAX_DEPTH));
    checkOutput("reset_no_ack", 32'(acks + 32'(bus.o_cfg_ack)), 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    last_y          = '0;
    rst             = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_x0        = '0;
    bus.i_cfg_req   = 1'b0;
    bus.i_cfg_delay = '0;
    modelClear(2);
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("rst_y0", 32'(bus.o_y0), 32'd0);
    checkOutput("rst_ack", 32'(bus.o_cfg_ack), 32'd0);
    checkOutput("rst_err", 32'(bus.o_cfg_err), 32'd0);
    checkOutput("rst_delay", 32'(bus.o_delay), 32'd2);
    rst = 1'b0;
    waitReady("ready_after_reset");
`ifdef VAR_DELAY_CNT_EN
    checkOutput("cnt_start", bus.o_acc_cnt, 32'd0);
`endif

    // Default delay 2, continuous stream
    for (int i = 1; i <= 5; i++) applyStimulus(DW'(i));
    repeat (2) @(negedge clk);
    checkOutput("drain_d2", 32'(exp_q.size()), 32'd0);

    // Zero delay
    requestDelay(0);
    applyStimulus(16'd7);
    applyStimulus(16'd8);
    @(negedge clk);

    // Maximum delay with pointer wrap
    requestDelay(MAX_DEPTH);
    for (int i = 1; i <= 12; i++) applyStimulus(DW'(i));

    // Rejected request while streaming
    bus.i_cfg_req   = 1'b1;
    bus.i_cfg_delay = DLW'(MAX_DEPTH + 1);
    bus.i_valid     = 1'b1;
    bus.i_x0        = 16'd13;
    modelAccept(16'd13);
    @(negedge clk);
    checkOutput("rej_ack", 32'(bus.o_cfg_ack), 32'd1);
    checkOutput("rej_err", 32'(bus.o_cfg_err), 32'd1);
    checkOutput("rej_ready", 32'(bus.o_ready), 32'd1);
    checkOutput("rej_delay", 32'(bus.o_delay), 32'(MAX_DEPTH));
    bus.i_cfg_req = 1'b0;
    bus.i_x0      = 16'd14;
    modelAccept(16'd14);
    @(negedge clk);
    bus.i_valid = 1'b0;
    checkOutput("rej_pulse", 32'({bus.o_cfg_ack, bus.o_cfg_err}), 32'd0);
    checkOutput("rej_ready2", 32'(bus.o_ready), 32'd1);
    applyStimulus(16'd15);
    @(negedge clk);

    // Gapped input with D=3: delay counts samples, not cycles
    requestDelay(3);
    applyStimulus(16'd1);
    @(negedge clk);
    checkOutput("gap_valid", 32'(bus.o_valid), 32'd0);
    checkOutput("gap_hold", 32'(bus.o_y0), 32'(last_y));
    applyStimulus(16'd2);
    repeat (2) begin
      @(negedge clk);
      checkOutput("gap_valid", 32'(bus.o_valid), 32'd0);
    end
    applyStimulus(16'd3);
    applyStimulus(16'd4);
    @(negedge clk);
    checkOutput("drain_gap", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a reconfiguration clear
    bus.i_cfg_req   = 1'b1;
    bus.i_cfg_delay = DLW'(5);
    repeat (4) @(negedge clk);
    rst           = 1'b1;
    bus.i_cfg_req = 1'b0;
    #1;
    checkOutput("midrst_delay", 32'(bus.o_delay), 32'd2);
    checkOutput("midrst_ready", 32'(bus.o_ready), 32'd0);
    checkOutput("midrst_ack", 32'(bus.o_cfg_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelClear(2);
    waitReady("ready_after_midrst");
    checkOutput("midrst_delay2", 32'(bus.o_delay), 32'd2);
`ifdef VAR_DELAY_CNT_EN
    checkOutput("cnt_zero", bus.o_acc_cnt, 32'd0);
`endif
    for (int i = 21; i <= 24; i++) applyStimulus(DW'(i));
`ifdef VAR_DELAY_CNT_EN
    checkOutput("cnt_four", bus.o_acc_cnt, 32'd4);
`endif
    repeat (2) @(negedge clk);
    checkOutput("drain_final", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
